// File: rtl/el_pkg.sv
`default_nettype none
// ============================================================================
// Module   : el_pkg
// Purpose  : Shared line-state encoding and default EL panel timing constants,
//            usable by both the frame reader and the frame-buffer input side.
// Revision : 1.0 - initial release
// ============================================================================
package el_pkg;

  // Per-line timing phases; the kind of line (VS/blank/active) is tracked by
  // a line counter in the reader, not by extra states.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HSYNC  = 3'd1,
    ST_HBACK  = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_HFRONT = 3'd4
  } line_state_t;

  // Default panel geometry: 320x240, 4 pixels per buffer word
  localparam int DEF_H_WORDS = 80;
  localparam int DEF_V_LINES = 240;
  localparam int DEF_H_BACK  = 4;
  localparam int DEF_V_BACK  = 2;

  // Fixed sync/porch lengths in clk cycles
  localparam int HSYNC_CYCLES  = 2;
  localparam int HFRONT_CYCLES = 2;

  // Frame-buffer word address width
  localparam int ADDR_W = 15;

  // Cycles per line for a given geometry (two clk cycles per pixel word)
  function automatic int line_cycles(input int h_words, input int h_back);
    return HSYNC_CYCLES + h_back + 2 * h_words + HFRONT_CYCLES;
  endfunction

endpackage : el_pkg
`default_nettype wire

// File: rtl/el_line_timer.sv
`default_nettype none
// ============================================================================
// Module   : el_line_timer
// Purpose  : Per-line phase sequencer. Walks HSYNC -> HBACK -> ACTIVE ->
//            HFRONT with a cycle counter and flags the last cycle of a line.
// Revision : 1.0 - initial release
// ============================================================================
module el_line_timer
  import el_pkg::*;
#(
  parameter int H_WORDS = DEF_H_WORDS,
  parameter int H_BACK  = DEF_H_BACK,
  parameter int CW      = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,     // leave IDLE at the next edge
  input  logic          cont,      // at line end: 1 = next line, 0 = IDLE
  output line_state_t   state,
  output logic [CW-1:0] cnt,
  output logic          line_done  // last cycle of the current line
);

  localparam logic [CW-1:0] HSYNC_LAST  = CW'(HSYNC_CYCLES - 1);
  localparam logic [CW-1:0] HBACK_LAST  = CW'(H_BACK - 1);
  localparam logic [CW-1:0] ACTIVE_LAST = CW'(2 * H_WORDS - 1);
  localparam logic [CW-1:0] HFRONT_LAST = CW'(HFRONT_CYCLES - 1);

  line_state_t   state_nxt;
  logic [CW-1:0] cnt_nxt;

  // Phase and in-phase cycle counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next phase: each phase runs until its last cycle, then the counter clears
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + CW'(1);
    line_done = 1'b0;
    case (state)
      ST_IDLE: begin
        cnt_nxt = '0;
        if (start) state_nxt = ST_HSYNC;
      end
      ST_HSYNC: begin
        if (cnt == HSYNC_LAST) begin
          state_nxt = ST_HBACK;
          cnt_nxt   = '0;
        end
      end
      ST_HBACK: begin
        if (cnt == HBACK_LAST) begin
          state_nxt = ST_ACTIVE;
          cnt_nxt   = '0;
        end
      end
      ST_ACTIVE: begin
        if (cnt == ACTIVE_LAST) begin
          state_nxt = ST_HFRONT;
          cnt_nxt   = '0;
        end
      end
      ST_HFRONT: begin
        if (cnt == HFRONT_LAST) begin
          line_done = 1'b1;
          cnt_nxt   = '0;
          state_nxt = cont ? ST_HSYNC : ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule : el_line_timer
`default_nettype wire

// File: rtl/el_frame_reader.sv
`default_nettype none
// ============================================================================
// Module   : el_frame_reader
// Purpose  : Scans a 4-bit-per-word frame buffer and drives an EL panel
//            (elData/elVclk/elHs/elVs). Line kind and read address are kept
//            here; per-line phase timing comes from el_line_timer.
// Revision : 1.0 - initial release
// ============================================================================
module el_frame_reader
  import el_pkg::*;
#(
  parameter int H_WORDS = DEF_H_WORDS,
  parameter int V_LINES = DEF_V_LINES,
  parameter int H_BACK  = DEF_H_BACK,
  parameter int V_BACK  = DEF_V_BACK
) (
  input  logic              elClk,
  input  logic              nReset,
  input  logic              enable,
  output logic [ADDR_W-1:0] rdAddr,
  output logic              rdEn,
  input  logic [3:0]        rdData,
  output logic [3:0]        elData,
  output logic              elVclk,
  output logic              elHs,
  output logic              elVs,
  output logic              frameStart
);

  localparam int LINES = 1 + V_BACK + V_LINES;
  localparam int LW    = $clog2(LINES + 1);
  localparam int CW    = $clog2(2 * H_WORDS + H_BACK + 1);

  localparam logic [LW-1:0]     LAST_LINE    = LW'(LINES - 1);
  localparam logic [LW-1:0]     FIRST_ACTIVE = LW'(V_BACK + 1);
  localparam logic [ADDR_W-1:0] LINE_STEP    = ADDR_W'(H_WORDS);

  line_state_t       state;
  logic [CW-1:0]     cnt;
  logic              line_done;
  logic              last_line;
  logic              active_line;
  logic              cont;
  logic [LW-1:0]     line;
  logic [ADDR_W-1:0] line_base;
  logic [ADDR_W-1:0] word;
  logic [3:0]        pix;
  logic              vclk_q;

  el_line_timer #(
    .H_WORDS (H_WORDS),
    .H_BACK  (H_BACK),
    .CW      (CW)
  ) u_timer (
    .clk       (elClk),
    .rst_n     (nReset),
    .start     (enable),
    .cont      (cont),
    .state     (state),
    .cnt       (cnt),
    .line_done (line_done)
  );

  // Line kind decode; enable only matters at the end of the last line
  always_comb begin
    last_line   = (line == LAST_LINE);
    active_line = (line >= FIRST_ACTIVE);
    cont        = !last_line || enable;
  end

  // Line counter and per-line base address (adds H_WORDS after each active line)
  always_ff @(posedge elClk or negedge nReset) begin
    if (!nReset) begin
      line      <= '0;
      line_base <= '0;
    end else if (state == ST_IDLE) begin
      line      <= '0;
      line_base <= '0;
    end else if (line_done) begin
      if (last_line) begin
        line      <= '0;
        line_base <= '0;
      end else begin
        line <= line + LW'(1);
        if (active_line) line_base <= line_base + LINE_STEP;
      end
    end
  end

  // Pixel launch: the odd ACTIVE cycle holds the RAM word (read in the even
  // cycle before); register it together with a rising elVclk so the data is
  // already stable when elVclk falls one cycle later.
  always_ff @(posedge elClk or negedge nReset) begin
    if (!nReset) begin
      pix    <= '0;
      vclk_q <= 1'b0;
    end else if (state == ST_IDLE || (line_done && !cont)) begin
      pix    <= '0;
      vclk_q <= 1'b0;
    end else begin
      vclk_q <= (state == ST_ACTIVE) && cnt[0];
      if ((state == ST_ACTIVE) && cnt[0]) begin
        pix <= active_line ? rdData : 4'h0;
      end
    end
  end

  // Panel sync, read strobe and address decode
  always_comb begin
    word       = ADDR_W'(cnt[CW-1:1]);
    rdEn       = (state == ST_ACTIVE) && active_line && !cnt[0];
    rdAddr     = rdEn ? (line_base + word) : '0;
    elHs       = (state == ST_HSYNC);
    elVs       = (state != ST_IDLE) && (line == '0);
    frameStart = (state == ST_HSYNC) && (cnt == '0) && (line == '0);
    elData     = pix;
    elVclk     = vclk_q;
  end

endmodule : el_frame_reader
`default_nettype wire

// File: tb/tb_el_frame_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_el_frame_reader
// Purpose  : Self-checking bench for el_frame_reader at default geometry.
// Revision : 1.0 - initial release
// ============================================================================
module tb_el_frame_reader;

  logic        elClk  = 1'b0;
  logic        nReset = 1'b0;
  logic        enable = 1'b0;
  logic [3:0]  rdData = 4'h0;
  logic [14:0] rdAddr;
  logic        rdEn;
  logic [3:0]  elData;
  logic        elVclk;
  logic        elHs;
  logic        elVs;
  logic        frameStart;

  int checks = 0;
  int errors = 0;

  el_frame_reader dut (
    .elClk      (elClk),
    .nReset     (nReset),
    .enable     (enable),
    .rdAddr     (rdAddr),
    .rdEn       (rdEn),
    .rdData     (rdData),
    .elData     (elData),
    .elVclk     (elVclk),
    .elHs       (elHs),
    .elVs       (elVs),
    .frameStart (frameStart)
  );

  always #5 elClk = ~elClk;

  // One-cycle-latency RAM whose content is the low nibble of the address
  always @(posedge elClk) if (rdEn) rdData <= rdAddr[3:0];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- monitor: per-frame statistics ----------------
  int   cyc = 0;
  int   frame_no = 0;
  int   fs_time [0:7];
  int   line_idx = 0;
  int   rd_cnt [0:3];
  int   rd_bad [0:3];
  int   vs_cnt [0:3];
  int   hs_pulses [0:3];
  int   hs_bad [0:3];
  int   max_addr [0:3];
  int   falls [0:3][0:242];
  int   hs_run = 0;
  logic prev_vclk = 1'b0;
  logic prev_hs = 1'b0;

  initial begin
    for (int f = 0; f < 4; f++) begin
      rd_cnt[f] = 0; rd_bad[f] = 0; vs_cnt[f] = 0;
      hs_pulses[f] = 0; hs_bad[f] = 0; max_addr[f] = 0;
      for (int l = 0; l < 243; l++) falls[f][l] = 0;
    end
  end

  always @(negedge elClk) begin
    cyc++;
    if (frameStart) begin
      if (frame_no < 8) fs_time[frame_no] = cyc;
      frame_no++;
      line_idx = 0;
    end else if (elHs && !prev_hs) begin
      line_idx++;
    end
    if (frame_no >= 1 && frame_no <= 2 && line_idx < 243) begin
      if (prev_vclk && !elVclk) falls[frame_no][line_idx]++;
      if (rdEn) begin
        rd_cnt[frame_no]++;
        if (line_idx < 3) rd_bad[frame_no]++;
        if (int'(rdAddr) > max_addr[frame_no]) max_addr[frame_no] = int'(rdAddr);
      end
      if (elVs) vs_cnt[frame_no]++;
      if (!elHs && prev_hs) begin
        hs_pulses[frame_no]++;
        if (hs_run != 2) hs_bad[frame_no]++;
      end
    end
    if (elHs) hs_run++;
    else hs_run = 0;
    prev_vclk = elVclk;
    prev_hs   = elHs;
  end

  // ---------------- vector table ----------------
  typedef struct {
    int          t;
    logic        fs, vs, hs, rden;
    logic [14:0] addr;
    logic        vclk;
    logic [3:0]  data;
    logic        chk_data;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(input int t, input logic fs, input logic vs, input logic hs,
                              input logic rden, input int addr, input logic vclk,
                              input int data, input logic chk_data);
    vec_t v;
    v.t = t; v.fs = fs; v.vs = vs; v.hs = hs; v.rden = rden;
    v.addr = 15'(addr); v.vclk = vclk; v.data = 4'(data); v.chk_data = chk_data;
    return v;
  endfunction

  task automatic wait_fs(input int bound, input string name);
    bit ok;
    ok = 0;
    for (int i = 0; i < bound && !ok; i++) begin
      @(negedge elClk);
      if (frameStart) ok = 1;
    end
    chk(name, {31'd0, ok}, 32'd1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rdEn"}, {31'd0, rdEn}, 0);
    chk({tag, "_rdAddr"}, {17'd0, rdAddr}, 0);
    chk({tag, "_elVs"}, {31'd0, elVs}, 0);
    chk({tag, "_elHs"}, {31'd0, elHs}, 0);
    chk({tag, "_elVclk"}, {31'd0, elVclk}, 0);
    chk({tag, "_elData"}, {28'd0, elData}, 0);
    chk({tag, "_frameStart"}, {31'd0, frameStart}, 0);
  endtask

  initial begin
    int cur;
    int bad;
    // t is cycles since frameStart; fs vs hs rdEn addr vclk data chk_data
    vt.push_back(mk(    0, 1, 1, 1, 0,     0, 0,  0, 1));
    vt.push_back(mk(    1, 0, 1, 1, 0,     0, 0,  0, 1));
    vt.push_back(mk(    2, 0, 1, 0, 0,     0, 0,  0, 1));
    vt.push_back(mk(    6, 0, 1, 0, 0,     0, 0,  0, 1));
    vt.push_back(mk(    8, 0, 1, 0, 0,     0, 1,  0, 1));
    vt.push_back(mk(  167, 0, 1, 0, 0,     0, 0,  0, 1));
    vt.push_back(mk(  168, 0, 0, 1, 0,     0, 0,  0, 1));
    vt.push_back(mk(  510, 0, 0, 0, 1,     0, 0,  0, 1));
    vt.push_back(mk(  511, 0, 0, 0, 0,     0, 0,  0, 1));
    vt.push_back(mk(  512, 0, 0, 0, 1,     1, 1,  0, 1));
    vt.push_back(mk(  514, 0, 0, 0, 1,     2, 1,  1, 1));
    vt.push_back(mk(  670, 0, 0, 0, 0,     0, 1, 15, 1));
    vt.push_back(mk(  671, 0, 0, 0, 0,     0, 0, 15, 1));
    vt.push_back(mk(  678, 0, 0, 0, 1,    80, 0, 15, 1));
    vt.push_back(mk(  680, 0, 0, 0, 1,    81, 1,  0, 1));
    vt.push_back(mk(40820, 0, 0, 0, 1, 19199, 1, 14, 1));
    vt.push_back(mk(40822, 0, 0, 0, 0,     0, 1, 15, 1));
    vt.push_back(mk(40823, 0, 0, 0, 0,     0, 0, 15, 1));
    vt.push_back(mk(40824, 1, 1, 1, 0,     0, 0,  0, 0));

    // Reset state, applied asynchronously from time zero
    #1;
    chk_all_zero("reset");
    repeat (2) @(negedge elClk);
    nReset = 1'b1;
    repeat (5) @(negedge elClk);
    chk("idle_no_frame", frame_no, 0);
    chk("idle_elVs", {31'd0, elVs}, 0);

    // Frame 1: enable held, walk the vector table
    enable = 1'b1;
    wait_fs(5, "first_frameStart");
    cur = 0;
    for (int i = 0; i < vt.size(); i++) begin
      repeat (vt[i].t - cur) @(negedge elClk);
      cur = vt[i].t;
      chk($sformatf("t%0d_frameStart", cur), {31'd0, frameStart}, {31'd0, vt[i].fs});
      chk($sformatf("t%0d_elVs", cur), {31'd0, elVs}, {31'd0, vt[i].vs});
      chk($sformatf("t%0d_elHs", cur), {31'd0, elHs}, {31'd0, vt[i].hs});
      chk($sformatf("t%0d_rdEn", cur), {31'd0, rdEn}, {31'd0, vt[i].rden});
      if (vt[i].rden) chk($sformatf("t%0d_rdAddr", cur), {17'd0, rdAddr}, {17'd0, vt[i].addr});
      chk($sformatf("t%0d_elVclk", cur), {31'd0, elVclk}, {31'd0, vt[i].vclk});
      if (vt[i].chk_data) chk($sformatf("t%0d_elData", cur), {28'd0, elData}, {28'd0, vt[i].data});
    end

    // Frame 2 has begun (t=0 of frame 2); drop enable at line 100
    repeat (100 * 168) @(negedge elClk);
    enable = 1'b0;
    repeat (40823 - 100 * 168) @(negedge elClk);
    chk("f2_last_cycle_elVs", {31'd0, elVs}, 0);
    chk("f2_last_cycle_elHs", {31'd0, elHs}, 0);
    @(negedge elClk);
    chk_all_zero("f2_idle");
    repeat (300) @(negedge elClk);
    chk("no_third_frame", frame_no, 2);

    // Frame statistics
    chk("frame_period", fs_time[1] - fs_time[0], 40824);
    chk("f1_vs_cycles", vs_cnt[1], 168);
    chk("f1_hs_pulses", hs_pulses[1], 243);
    chk("f1_hs_bad_width", hs_bad[1], 0);
    chk("f1_rd_pulses", rd_cnt[1], 19200);
    chk("f1_rd_on_blank", rd_bad[1], 0);
    chk("f1_max_addr", max_addr[1], 19199);
    chk("f2_rd_pulses", rd_cnt[2], 19200);
    chk("f2_hs_pulses", hs_pulses[2], 243);
    bad = 0;
    for (int l = 0; l < 243; l++) if (falls[1][l] != 80) bad++;
    chk("f1_lines_without_80_falls", bad, 0);
    bad = 0;
    for (int l = 0; l < 243; l++) if (falls[2][l] != 80) bad++;
    chk("f2_lines_without_80_falls", bad, 0);

    // Reset pulsed mid-ACTIVE on the first active line
    enable = 1'b1;
    wait_fs(5, "pre_reset_frameStart");
    repeat (530) @(negedge elClk);
    chk("pre_reset_rdEn", {31'd0, rdEn}, 1);
    #2 nReset = 1'b0;
    #1;
    chk_all_zero("mid_reset");
    @(negedge elClk);
    nReset = 1'b1;
    wait_fs(5, "post_reset_frameStart");
    repeat (510) @(negedge elClk);
    chk("post_reset_rdEn", {31'd0, rdEn}, 1);
    chk("post_reset_rdAddr", {17'd0, rdAddr}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_el_frame_reader
`default_nettype wire
